// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: shifts out a 48-bit command frame with CRC7,
// then polls MISO for the R1 response byte (or times out after NCR_MAX bytes).
module sd_spi_cmd_engine #(
  parameter int CLK_DIV = 125,  // clocks per SCLK half-period, >= 2
  parameter int NCR_MAX = 8     // response-wait bytes before timeout
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  resp_o,
  output logic        timeout_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_cs_n_o
);

  localparam int CW        = $clog2(2 * CLK_DIV);
  localparam int WAIT_BITS = NCR_MAX * 8;
  localparam int BW        = $clog2((WAIT_BITS > 48) ? WAIT_BITS : 48);

  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);

  localparam logic [BW-1:0] CRC_LAST  = BW'(39);
  localparam logic [BW-1:0] SEND_LAST = BW'(47);
  localparam logic [BW-1:0] WAIT_LAST = BW'(WAIT_BITS - 1);
  localparam logic [BW-1:0] RECV_LAST = BW'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_RECV, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;       // position within one SPI bit
  logic [BW-1:0] bcnt_q, bcnt_d;     // bit index within the current state
  logic [47:0]   sh_q, sh_d;         // outgoing frame, MSB is on the wire
  logic [6:0]    crc_q, crc_d;
  logic [7:0]    rx_q, rx_d;         // MISO sample shifter
  logic [7:0]    resp_q, resp_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;

  logic bit_end, rise, active_q;
  logic [6:0] crc_nxt;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign rise     = (cnt_q == CNT_RISE);
  assign active_q = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_RECV);

  // CRC7 (x^7 + x^3 + 1) advanced by the bit currently on MOSI
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign crc_nxt = crc7_step(crc_q, sh_q[47]);

  // State and registered outputs; outputs are registered so SCLK/MOSI/CS are glitch-free
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      crc_q     <= '0;
      rx_q      <= 8'hFF;
      resp_q    <= 8'hFF;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      crc_q     <= crc_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  // Next state: transitions happen only at SPI bit boundaries (plus IDLE/FIN)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_start_i) state_d = S_SEND;
      S_SEND: if (bit_end && bcnt_q == SEND_LAST) state_d = S_WAIT;
      S_WAIT: if (bit_end) begin
        if (!rx_q[0])               state_d = S_RECV;  // start bit sampled this bit
        else if (bcnt_q == WAIT_LAST) state_d = S_FIN;
      end
      S_RECV: if (bit_end && bcnt_q == RECV_LAST) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: bit timer, frame shifter with CRC insertion, MISO capture, result
  always_comb begin
    cnt_d     = '0;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    if (active_q) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (cmd_start_i) begin
        sh_d      = {2'b01, cmd_index_i, cmd_arg_i, 8'h00};
        crc_d     = '0;
        bcnt_d    = '0;
        rx_d      = 8'hFF;
        timeout_d = 1'b0;
      end
      S_SEND: if (bit_end) begin
        sh_d = {sh_q[46:0], 1'b1};
        if (bcnt_q <= CRC_LAST) crc_d = crc_nxt;
        // after the 40th payload bit the CRC and end bit take the top byte
        if (bcnt_q == CRC_LAST) sh_d[47:40] = {crc_nxt, 1'b1};
        bcnt_d = (bcnt_q == SEND_LAST) ? '0 : bcnt_q + 1'b1;
      end
      S_WAIT: begin
        if (rise) rx_d = {rx_q[6:0], spi_miso_i};
        if (bit_end) begin
          if (!rx_q[0]) begin
            bcnt_d = BW'(1);  // start bit already holds resp[7]
          end else if (bcnt_q == WAIT_LAST) begin
            resp_d    = 8'hFF;
            timeout_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_RECV: begin
        if (rise) rx_d = {rx_q[6:0], spi_miso_i};
        if (bit_end) begin
          if (bcnt_q == RECV_LAST) resp_d = rx_q;
          else                     bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state so each pin changes on the same edge as its state
  always_comb begin
    busy_d = (state_d == S_SEND) || (state_d == S_WAIT) || (state_d == S_RECV);
    cs_n_d = !busy_d;
    done_d = (state_d == S_FIN);
    sclk_d = busy_d && (cnt_d >= CNT_HALF);
    mosi_d = (state_d == S_SEND) ? sh_d[47] : 1'b1;
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign resp_o     = resp_q;
  assign timeout_o  = timeout_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule
